call_modules_core: RTL and testbench

// - Single-issue execute core: decodes a 32-bit instruction word, reads a 32x32 register file, runs an 8-op ALU.
// - Writes the result back to the register file and presents it registered on alu_out.
// - Top-level wrapper tying decoder, regfile and ALU together; sits behind instruction fetch.

---
 rtl/call_modules_core.sv | 134 +++++++++++++
 tb/tb_call_modules_core.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/call_modules_core.sv
// ---------------------------------------------------------------------------
// call_modules_core
// Single-issue execute core. Each rising edge it decodes one 32-bit
// instruction word, reads two operands from a 32 x 32 register file, runs an
// 8-operation ALU, writes the result back to the destination register and
// presents the same result on a registered output.
//
// Ports
//   clk      in   1       single clock, all state changes on the rising edge
//   rst      in   1       synchronous active-low reset
//   inst     in   32      instruction word, sampled every rising edge
//   alu_out  out  DATA_W  registered result of the last executed instruction
//
// Instruction fields
//   [31:30] class (only 2'b01 executes, anything else is a NOP)
//   [29]    immediate form
//   [28:26] op: AND, OR, ADD, SUB, XOR, SLTU, SHL, SHR (logical)
//   [25:21] rd, [20:16] rs1
//   [15:0]  imm (immediate form) / [15:11] rs2 (register form)
//
// Configuration
//   SIGNED_IMM_EN  defined: immediates are sign-extended.
//                  undefined (default): immediates are zero-extended.
//                  Register-form instructions are unaffected.
// ---------------------------------------------------------------------------
module call_modules_core #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int IMM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       inst,
    output logic [DATA_W-1:0] alu_out
);

    localparam int NUM_REGS = 2 ** REG_AW;
    localparam int SH_W     = $clog2(DATA_W);

    // Result of one ALU operation; carries, borrows and overflow are dropped.
    function automatic logic [DATA_W-1:0] alu_eval(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] res;
        res = {DATA_W{1'b0}};
        case (op)
            3'b000:  res = a & b;
            3'b001:  res = a | b;
            3'b010:  res = a + b;
            3'b011:  res = a - b;
            3'b100:  res = a ^ b;
            3'b101:  res = {{(DATA_W-1){1'b0}}, (a < b)};
            3'b110:  res = a << b[SH_W-1:0];
            3'b111:  res = a >> b[SH_W-1:0];
            default: res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    // Architectural state
    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic [DATA_W-1:0] alu_out_r;

    // Decoded fields and datapath nets
    logic              exec_s;
    logic              imm_form_s;
    logic [2:0]        op_s;
    logic [REG_AW-1:0] rd_s;
    logic [REG_AW-1:0] rs1_s;
    logic [REG_AW-1:0] rs2_s;
    logic [IMM_W-1:0]  imm_s;
    logic [DATA_W-1:0] imm_ext_s;
    logic [DATA_W-1:0] opa_s;
    logic [DATA_W-1:0] opb_s;
    logic [DATA_W-1:0] result_s;

    // Instruction decode: split the word into its fields.
    always_comb begin
        exec_s     = (inst[31:30] == 2'b01);
        imm_form_s = inst[29];
        op_s       = inst[28:26];
        rd_s       = inst[21 +: REG_AW];
        rs1_s      = inst[16 +: REG_AW];
        rs2_s      = inst[11 +: REG_AW];
        imm_s      = inst[IMM_W-1:0];
    end

    // Immediate extension, selected at build time.
    always_comb begin
`ifdef SIGNED_IMM_EN
        imm_ext_s = {{(DATA_W-IMM_W){imm_s[IMM_W-1]}}, imm_s};
`else
        imm_ext_s = {{(DATA_W-IMM_W){1'b0}}, imm_s};
`endif
    end

    // Operand fetch: reads see pre-edge register contents, so rd==rs reads
    // the old value and the following instruction sees the new one.
    always_comb begin
        opa_s = regs_r[rs1_s];
        if (imm_form_s) begin
            opb_s = imm_ext_s;
        end else begin
            opb_s = regs_r[rs2_s];
        end
        result_s = alu_eval(op_s, opa_s, opb_s);
    end

    // Register file write-back; R0 is an ordinary register. Reset wins over
    // any instruction presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (exec_s) begin
            regs_r[rd_s] <= result_s;
        end
    end

    // Registered result; held across NOPs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            alu_out_r <= {DATA_W{1'b0}};
        end else if (exec_s) begin
            alu_out_r <= result_s;
        end
    end

    assign alu_out = alu_out_r;

endmodule

// File: tb/tb_call_modules_core.sv
module tb_call_modules_core;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic [31:0] alu_out;

    int checks;
    int passes;

    // Reference model state: plain array of register values and last result.
    logic [31:0] m_regs [32];
    logic [31:0] m_out;

    call_modules_core dut (
        .clk    (clk),
        .rst    (rst),
        .inst   (inst),
        .alu_out(alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [2:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {2'b01, 1'b1, op, rd, rs1, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [2:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {2'b01, 1'b0, op, rd, rs1, rs2, 11'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Behavioural model plus per-cycle comparison of alu_out.
    always @(posedge clk) begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [4:0]  rd;
        if (!rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            m_out = 32'd0;
        end else if (inst[31:30] == 2'b01) begin
            rd = inst[25:21];
            a  = m_regs[inst[20:16]];
            if (inst[29]) begin
`ifdef SIGNED_IMM_EN
                b = 32'(signed'(inst[15:0]));
`else
                b = {16'd0, inst[15:0]};
`endif
            end else begin
                b = m_regs[inst[15:11]];
            end
            case (inst[28:26])
                3'd0: r = a & b;
                3'd1: r = a | b;
                3'd2: r = a + b;
                3'd3: r = a - b;
                3'd4: r = a ^ b;
                3'd5: r = (a < b) ? 32'd1 : 32'd0;
                3'd6: r = a << (b % 32);
                default: r = a >> (b % 32);
            endcase
            m_regs[rd] = r;
            m_out = r;
        end
        #1;
        check("model_cycle", alu_out, m_out);
    end

    task automatic step(input logic [31:0] w);
        @(negedge clk);
        inst = w;
        @(posedge clk);
        #2;
    endtask

    logic [31:0] exp_r [8] = '{32'h00009425, 32'h00009735, 32'h00012B5A, 32'hFFFFFEF0,
                               32'h00000310, 32'h00000001, 32'hA4A00000, 32'h00000000};
    logic [31:0] rw;

    initial begin
        checks = 0;
        passes = 0;
        rst  = 1'b0;
        inst = 32'd0;
        @(posedge clk);
        #2;
        check("reset_alu_out", alu_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reading R0/R1 non-destructively via ORI rX,rX,0
        step(enc_i(3'd1, 5'd0, 5'd0, 16'h0000));
        check("r0_after_reset", alu_out, 32'd0);
        step(enc_i(3'd1, 5'd1, 5'd1, 16'h0000));
        check("r1_after_reset", alu_out, 32'd0);

        step(enc_i(3'd2, 5'd0, 5'd1, 16'h9525));
        check("addi_r0", alu_out, 32'h00009525);
        step(enc_i(3'd2, 5'd1, 5'd1, 16'h9635));
        check("addi_r1", alu_out, 32'h00009635);

        for (int op = 0; op < 8; op++) begin
            step(enc_r(3'(op), 5'd2, 5'd0, 5'd1));
            check($sformatf("rform_op%0d", op), alu_out, exp_r[op]);
            step(enc_i(3'd1, 5'd2, 5'd2, 16'h0000));
            check($sformatf("r2_tracks_op%0d", op), alu_out, exp_r[op]);
        end

        step(32'h0000_0000);
        check("nop_hold_zero", alu_out, 32'd0);
        step(enc_i(3'd1, 5'd0, 5'd0, 16'h0000));
        check("r0_unchanged", alu_out, 32'h00009525);
        step(32'hC000_FFFF);
        check("nop_hold_nonzero", alu_out, 32'h00009525);
        step(enc_i(3'd1, 5'd1, 5'd1, 16'h0000));
        check("r1_unchanged", alu_out, 32'h00009635);

        // Back-to-back dependency on the freshly written value
        step(enc_i(3'd2, 5'd5, 5'd5, 16'h0001));
        check("dep_first", alu_out, 32'd1);
        step(enc_i(3'd2, 5'd5, 5'd5, 16'h0001));
        check("dep_second", alu_out, 32'd2);

        step(enc_i(3'd2, 5'd3, 5'd31, 16'h9525));
`ifdef SIGNED_IMM_EN
        check("addi_imm_ext", alu_out, 32'hFFFF9525);
`else
        check("addi_imm_ext", alu_out, 32'h00009525);
`endif

        // Mid-stream reset overrides an executing instruction
        @(negedge clk);
        rst  = 1'b0;
        inst = enc_i(3'd2, 5'd4, 5'd0, 16'h1234);
        @(posedge clk);
        #2;
        check("midstream_reset", alu_out, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        step(enc_i(3'd1, 5'd0, 5'd0, 16'h0000));
        check("r0_cleared", alu_out, 32'd0);

        // Randomized traffic with dependency-heavy register selection
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            rw = $urandom;
            if ($urandom_range(0, 9) < 8) rw[31:30] = 2'b01;
            if ($urandom_range(0, 1) == 1) begin
                rw[25:21] = 5'($urandom_range(0, 3));
                rw[20:16] = 5'($urandom_range(0, 3));
                rw[15:11] = 5'($urandom_range(0, 3));
            end
            rst  = ($urandom_range(0, 59) != 0);
            inst = rw;
        end
        @(negedge clk);
        rst  = 1'b1;
        inst = 32'd0;
        @(posedge clk);
        #3;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
